cd_tx_loader: RTL and testbench



---
 rtl/cd_tx_loader_pkg.sv | 43 ++++
 rtl/cd_csr_poller.sv | 54 +++++
 rtl/cd_tx_loader.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cd_tx_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_tx_loader_pkg.sv
// -----------------------------------------------------------------------------
// cd_tx_loader_pkg
// Shared definitions for the CDBUS TX loader:
//   - state_t        : sequencer states
//   - ERR_*          : err_code values reported with frame_err
//   - DEF_*          : default CSR addresses, INT_FLAG bit indices, TX_CTRL
//                      command values, frame length limit and timeout
//   - sat_inc16()    : saturating 16-bit increment used by the statistics
// -----------------------------------------------------------------------------
package cd_tx_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POLL_BUF = 3'd1,
    LOAD     = 3'd2,
    DROP     = 3'd3,
    SWITCH   = 3'd4,
    POLL_TX  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;  // frame longer than MAX_LEN
  localparam logic [1:0] ERR_TX   = 2'd2;  // core reported a TX error
  localparam logic [1:0] ERR_TMO  = 2'd3;  // no completion within TIMEOUT

  localparam logic [4:0] DEF_ADDR_INT_FLAG = 5'h10;
  localparam logic [4:0] DEF_ADDR_TX       = 5'h15;
  localparam logic [4:0] DEF_ADDR_TX_CTRL  = 5'h17;

  localparam int DEF_BIT_BUF_CLEAN = 5;
  localparam int DEF_BIT_TX_ERR    = 7;

  localparam logic [7:0] DEF_CTRL_SWITCH = 8'h02;
  localparam logic [7:0] DEF_CTRL_ABORT  = 8'h04;

  localparam int          DEF_MAX_LEN = 256;
  localparam logic [19:0] DEF_TIMEOUT = 20'd1000000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cd_csr_poller.sv
// -----------------------------------------------------------------------------
// cd_csr_poller
// Issues single-cycle CSR reads while poll_req is high and flags the cycle in
// which the read data is valid. Reads are spaced two cycles apart: one cycle
// with csr_read high, one cycle in which csr_readdata is presented and the
// owner decides whether another read is needed.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   poll_req       owner wants (another) read; must already be low in the
//                  sample cycle if the owner is about to stop polling
//   csr_readdata   read data from the core, valid the cycle after csr_read
//   rd_issue       a read is launched at the coming edge (owner uses it to
//                  steer its registered address)
//   csr_read       registered read strobe to the core
//   sample_valid   sample_flags holds the response to the last read
//   sample_flags   response byte (pass-through of csr_readdata)
// -----------------------------------------------------------------------------
module cd_csr_poller (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_req,
  input  logic [7:0] csr_readdata,
  output logic       rd_issue,
  output logic       csr_read,
  output logic       sample_valid,
  output logic [7:0] sample_flags
);

  logic rd_reg;    // read strobe currently on the bus
  logic wait_reg;  // response to the previous read is on csr_readdata

  // Never launch in the cycle the strobe is already high, which yields the
  // read / sample / read / sample cadence.
  assign rd_issue = poll_req && !rd_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg   <= 1'b0;
      wait_reg <= 1'b0;
    end else begin
      rd_reg   <= rd_issue;
      wait_reg <= rd_reg;
    end
  end

  // The response is consumed in the cycle it is valid so that the owner's
  // registered decision lands on the very next edge; registering it here
  // would stretch each poll to three cycles.
  assign csr_read     = rd_reg;
  assign sample_valid = wait_reg;
  assign sample_flags = csr_readdata;

endmodule

// File: rtl/cd_tx_loader.sv
// -----------------------------------------------------------------------------
// cd_tx_loader
// Autonomous TX sequencer: takes frames from a byte stream and loads them into
// the CDBUS core through its 8-bit CSR port. For each frame it polls INT_FLAG
// until a TX buffer is clean, writes the bytes to the TX data port, commits
// with a switch command and then polls for completion under a timeout.
// Overlength frames are drained and aborted.
//
// Build option: define CD_TX_LOADER_STATS_EN to build saturating frame
// counters behind stat_ok / stat_err; otherwise both ports read 0.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   s_data, s_valid, s_last,        frame byte stream; a byte is taken when
//   s_ready                         s_valid && s_ready
//   csr_address, csr_read,          registered CSR master towards the core;
//   csr_write, csr_writedata        read data returns on csr_readdata one
//   csr_readdata                    cycle after csr_read
//   busy                            sequencer not idle
//   frame_done                      1-cycle pulse, frame committed and sent
//   frame_err                       1-cycle pulse, frame failed
//   err_code                        cause of the last frame_err (held)
//   stat_ok, stat_err               completed / failed frame counters
//
// TIMEOUT must be at least 1.
// -----------------------------------------------------------------------------
module cd_tx_loader
  import cd_tx_loader_pkg::*;
#(
  parameter logic [4:0]  ADDR_INT_FLAG = DEF_ADDR_INT_FLAG,
  parameter logic [4:0]  ADDR_TX       = DEF_ADDR_TX,
  parameter logic [4:0]  ADDR_TX_CTRL  = DEF_ADDR_TX_CTRL,
  parameter int          BIT_BUF_CLEAN = DEF_BIT_BUF_CLEAN,
  parameter int          BIT_TX_ERR    = DEF_BIT_TX_ERR,
  parameter logic [7:0]  CTRL_SWITCH   = DEF_CTRL_SWITCH,
  parameter logic [7:0]  CTRL_ABORT    = DEF_CTRL_ABORT,
  parameter int          MAX_LEN       = DEF_MAX_LEN,
  parameter logic [19:0] TIMEOUT       = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [4:0]  csr_address,
  output logic        csr_read,
  input  logic [7:0]  csr_readdata,
  output logic        csr_write,
  output logic [7:0]  csr_writedata,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err
);

  localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);

  state_t      state_reg;
  logic [8:0]  len_reg;
  logic [19:0] timer_reg;
  logic        s_ready_reg;
  logic        busy_reg;
  logic [4:0]  csr_address_reg;
  logic        csr_write_reg;
  logic [7:0]  csr_writedata_reg;
  logic        frame_done_reg;
  logic        frame_err_reg;
  logic [1:0]  err_code_reg;

  logic        poll_req;
  logic        rd_issue;
  logic        sample_valid;
  logic [7:0]  sample_flags;
  logic        accept;
  logic        buf_clean;
  logic        tx_err;
  logic        tmo_hit;

  // Only BUF_CLEAN and TX_ERR matter; the other INT_FLAG bits are ignored.
  logic        unused_flag_bits;
  assign unused_flag_bits = ^sample_flags;

  assign accept    = s_valid && s_ready_reg;
  assign buf_clean = sample_valid && sample_flags[BIT_BUF_CLEAN];
  assign tx_err    = sample_valid && sample_flags[BIT_TX_ERR];
  // The timer would hit zero with this cycle's decrement.
  assign tmo_hit   = (timer_reg == 20'd1);

  // Keep polling unless this cycle's sample (or the timer) ends the poll, so
  // no stray read follows the decision.
  always_comb begin
    poll_req = 1'b0;
    case (state_reg)
      POLL_BUF: poll_req = !buf_clean;
      POLL_TX:  poll_req = !(tx_err || buf_clean) && !tmo_hit;
      default:  poll_req = 1'b0;
    endcase
  end

  cd_csr_poller u_poller (
    .clk          (clk),
    .reset        (reset),
    .poll_req     (poll_req),
    .csr_readdata (csr_readdata),
    .rd_issue     (rd_issue),
    .csr_read     (csr_read),
    .sample_valid (sample_valid),
    .sample_flags (sample_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      len_reg           <= '0;
      timer_reg         <= '0;
      s_ready_reg       <= 1'b0;
      busy_reg          <= 1'b0;
      csr_address_reg   <= '0;
      csr_write_reg     <= 1'b0;
      csr_writedata_reg <= '0;
      frame_done_reg    <= 1'b0;
      frame_err_reg     <= 1'b0;
      err_code_reg      <= ERR_NONE;
    end else begin
      // Single-cycle defaults; the bus idles at address 0 between accesses.
      csr_write_reg     <= 1'b0;
      csr_writedata_reg <= '0;
      csr_address_reg   <= rd_issue ? ADDR_INT_FLAG : 5'd0;
      frame_done_reg    <= 1'b0;
      frame_err_reg     <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (s_valid) begin
            state_reg <= POLL_BUF;
            busy_reg  <= 1'b1;
          end
        end

        POLL_BUF: begin
          if (buf_clean) begin
            state_reg   <= LOAD;
            s_ready_reg <= 1'b1;
            len_reg     <= '0;
          end
        end

        LOAD: begin
          if (accept) begin
            if (len_reg == MAX_LEN_L) begin
              // Overlength: this byte is not written. If it also ends the
              // frame there is nothing left to drain.
              if (s_last) begin
                csr_write_reg     <= 1'b1;
                csr_address_reg   <= ADDR_TX_CTRL;
                csr_writedata_reg <= CTRL_ABORT;
                frame_err_reg     <= 1'b1;
                err_code_reg      <= ERR_LEN;
                s_ready_reg       <= 1'b0;
                busy_reg          <= 1'b0;
                state_reg         <= IDLE;
              end else begin
                state_reg <= DROP;
              end
            end else begin
              csr_write_reg     <= 1'b1;
              csr_address_reg   <= ADDR_TX;
              csr_writedata_reg <= s_data;
              len_reg           <= len_reg + 9'd1;
              if (s_last) begin
                s_ready_reg <= 1'b0;
                state_reg   <= SWITCH;
              end
            end
          end
        end

        DROP: begin
          if (accept && s_last) begin
            csr_write_reg     <= 1'b1;
            csr_address_reg   <= ADDR_TX_CTRL;
            csr_writedata_reg <= CTRL_ABORT;
            frame_err_reg     <= 1'b1;
            err_code_reg      <= ERR_LEN;
            s_ready_reg       <= 1'b0;
            busy_reg          <= 1'b0;
            state_reg         <= IDLE;
          end
        end

        SWITCH: begin
          csr_write_reg     <= 1'b1;
          csr_address_reg   <= ADDR_TX_CTRL;
          csr_writedata_reg <= CTRL_SWITCH;
          timer_reg         <= TIMEOUT;
          state_reg         <= POLL_TX;
        end

        POLL_TX: begin
          // Error wins over a simultaneous clean flag; a real sample wins
          // over the timeout in the same cycle.
          if (tx_err) begin
            csr_write_reg     <= 1'b1;
            csr_address_reg   <= ADDR_TX_CTRL;
            csr_writedata_reg <= CTRL_ABORT;
            frame_err_reg     <= 1'b1;
            err_code_reg      <= ERR_TX;
            busy_reg          <= 1'b0;
            state_reg         <= IDLE;
          end else if (buf_clean) begin
            frame_done_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end else if (tmo_hit) begin
            csr_write_reg     <= 1'b1;
            csr_address_reg   <= ADDR_TX_CTRL;
            csr_writedata_reg <= CTRL_ABORT;
            frame_err_reg     <= 1'b1;
            err_code_reg      <= ERR_TMO;
            timer_reg         <= '0;
            busy_reg          <= 1'b0;
            state_reg         <= IDLE;
          end else begin
            timer_reg <= timer_reg - 20'd1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          s_ready_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready       = s_ready_reg;
  assign busy          = busy_reg;
  assign csr_address   = csr_address_reg;
  assign csr_write     = csr_write_reg;
  assign csr_writedata = csr_writedata_reg;
  assign frame_done    = frame_done_reg;
  assign frame_err     = frame_err_reg;
  assign err_code      = err_code_reg;

`ifdef CD_TX_LOADER_STATS_EN
  // Index 0 counts completed frames, index 1 failed frames.
  logic [1:0] stat_inc;
  assign stat_inc = {frame_err_reg, frame_done_reg};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi]) begin
        cnt_reg <= sat_inc16(cnt_reg);
      end
    end
  end

  assign stat_ok  = g_stat[0].cnt_reg;
  assign stat_err = g_stat[1].cnt_reg;
`else
  assign stat_ok  = 16'd0;
  assign stat_err = 16'd0;
`endif

endmodule

// File: tb/tb_cd_tx_loader.sv
// -----------------------------------------------------------------------------
// tb_cd_tx_loader
// Randomised frames against a small CDBUS core model. Each frame's expected
// CSR traffic and outcome are derived from the frame length and the scripted
// INT_FLAG responses; one line is printed per frame.
// -----------------------------------------------------------------------------
module tb_cd_tx_loader;

  localparam int MAXL = 256;
  localparam int TMO  = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [4:0]  csr_address;
  logic        csr_read;
  logic [7:0]  csr_readdata = 8'h00;
  logic        csr_write;
  logic [7:0]  csr_writedata;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] stat_ok;
  logic [15:0] stat_err;

  always #5 clk = ~clk;

  cd_tx_loader #(.TIMEOUT(20'd50)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .stat_ok       (stat_ok),
    .stat_err      (stat_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- core model / bus monitor ----------------
  int          cyc = 0;
  int          buf_zero = 0, buf_cnt = 0, tx_zero = 0, tx_cnt = 0;
  logic [7:0]  tx_resp = 8'h20;
  bit          after_switch = 0;
  bit          rd_pend = 0;
  logic [7:0]  rd_val = 8'h00;
  logic [7:0]  tx_q[$];
  logic [7:0]  ctrl_q[$];
  int          switch_cyc = 0, abort_cyc = 0;
  int          done_seen = 0, err_seen = 0;
  logic [1:0]  err_code_at = 2'd0;
  int          early_tx = 0, rw_both = 0, bad_addr = 0;
  int          first_op = 0;  // 0 none, 1 read, 2 write

  always @(posedge clk) begin
    #1;
    cyc++;
    // Response of the previous cycle's read, otherwise noise.
    csr_readdata = rd_pend ? rd_val : 8'($urandom);
    rd_pend = 1'b0;
    if (!reset) begin
      if (csr_read && csr_write) rw_both++;
      if (csr_read) begin
        if (first_op == 0) first_op = 1;
        if (csr_address != 5'h10) bad_addr++;
        rd_pend = 1'b1;
        if (!after_switch) begin
          rd_val = (buf_cnt < buf_zero) ? 8'h00 : 8'h20;
          buf_cnt++;
        end else begin
          rd_val = (tx_cnt < tx_zero) ? 8'h00 : tx_resp;
          tx_cnt++;
        end
      end
      if (csr_write) begin
        if (first_op == 0) first_op = 2;
        if (csr_address == 5'h15) begin
          tx_q.push_back(csr_writedata);
          if (buf_cnt <= buf_zero) early_tx++;
        end else if (csr_address == 5'h17) begin
          ctrl_q.push_back(csr_writedata);
          if (csr_writedata == 8'h02) begin
            after_switch = 1'b1;
            switch_cyc = cyc;
          end
          if (csr_writedata == 8'h04) abort_cyc = cyc;
        end else begin
          bad_addr++;
        end
      end
      if (frame_done) done_seen++;
      if (frame_err) begin
        err_seen++;
        err_code_at = err_code;
      end
    end
  end

  // ---------------- reference bookkeeping ----------------
  int         ok_cnt = 0, err_cnt = 0;
  logic [1:0] last_err = 2'd0;
  int         frame_no = 0;

  task automatic push_byte(input logic [7:0] d, input bit last, output bit ok);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    ok = s_ready;
    if (ok) @(negedge clk);
  endtask

  task automatic model_start(input int bz, input int tz, input logic [7:0] tr);
    tx_q.delete();
    ctrl_q.delete();
    buf_cnt = 0; tx_cnt = 0; after_switch = 0;
    done_seen = 0; err_seen = 0; early_tx = 0;
    buf_zero = bz; tx_zero = tz; tx_resp = tr;
    switch_cyc = 0; abort_cyc = 0;
  endtask

  task automatic run_frame(input logic [7:0] fd[$], input int bz, input int tz, input logic [7:0] tr);
    int len, exp_out, obs_out, w, ndiff, n_tx_exp, lat;
    bit ok;
    logic [23:0] exp_ctrl, obs_ctrl;
    len = fd.size();
    model_start(bz, tz, tr);
    n_tx_exp = (len > MAXL) ? MAXL : len;
    if (len > MAXL)  exp_out = 1;
    else if (tr[7])  exp_out = 2;
    else if (tr[5])  exp_out = 0;
    else             exp_out = 3;

    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      push_byte(fd[i], (i == len - 1), ok);
      if (!ok) begin
        check("accept_bound", 32'd0, 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    w = 0;
    while (done_seen + err_seen == 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);

    obs_out = (err_seen != 0) ? int'(err_code_at) : ((done_seen != 0) ? 0 : 7);
    check("outcome", obs_out, exp_out);
    check("pulse_cnt", done_seen + err_seen, 1);
    check("tx_writes", tx_q.size(), n_tx_exp);
    ndiff = 0;
    for (int i = 0; i < n_tx_exp && i < tx_q.size(); i++)
      if (tx_q[i] !== fd[i]) ndiff++;
    check("tx_bytes", ndiff, 0);
    if (len > MAXL)        exp_ctrl = {8'd1, 8'h04, 8'h00};
    else if (exp_out == 0) exp_ctrl = {8'd1, 8'h02, 8'h00};
    else                   exp_ctrl = {8'd2, 8'h02, 8'h04};
    obs_ctrl = {8'(ctrl_q.size()),
                (ctrl_q.size() > 0) ? ctrl_q[0] : 8'h00,
                (ctrl_q.size() > 1) ? ctrl_q[1] : 8'h00};
    check("ctrl_seq", obs_ctrl, exp_ctrl);
    check("buf_polls", buf_cnt, bz + 1);
    check("load_early", early_tx, 0);
    lat = abort_cyc - switch_cyc;
    if (exp_out == 3) check("tmo_window", (lat <= TMO && lat >= TMO - 2), 1);
    if (exp_out != 0) last_err = 2'(exp_out);
    if (exp_out == 0) ok_cnt++; else err_cnt++;
    check("err_code_hold", err_code, last_err);
    check("busy_idle", busy, 0);
    $display("frame %0d len=%0d buf_wait=%0d tx_flag=%02h outcome=%0d expected=%0d tx_writes=%0d",
             frame_no, len, bz, tr, obs_out, exp_out, tx_q.size());
    frame_no++;
  endtask

  function automatic void rand_frame(input int len, output logic [7:0] fd[$]);
    fd.delete();
    for (int i = 0; i < len; i++) fd.push_back(8'($urandom));
  endfunction

  task automatic check_stats(input string tag);
    int exp_ok, exp_er;
`ifdef CD_TX_LOADER_STATS_EN
    exp_ok = ok_cnt;
    exp_er = err_cnt;
`else
    exp_ok = 0;
    exp_er = 0;
`endif
    check({tag, "_ok"}, stat_ok, exp_ok);
    check({tag, "_err"}, stat_err, exp_er);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fd[$];
    logic [7:0] tr_tab[4];
    logic [20:0] outs;
    bit ok;
    int len;
    tr_tab = '{8'h20, 8'hA0, 8'h80, 8'h00};

    #1;
    outs = {csr_address, csr_read, csr_write, csr_writedata, s_ready, busy,
            frame_done, frame_err, err_code};
    check("reset_outs", outs, 21'd0);
    check("reset_stats", {stat_ok, stat_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: 11,22,33,44 with an immediately clean buffer.
    fd = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(fd, 0, 0, 8'h20);
    // Buffer busy for three polls.
    rand_frame(5, fd);        run_frame(fd, 3, 0, 8'h20);
    // Overlength 300 bytes.
    rand_frame(300, fd);      run_frame(fd, 0, 0, 8'h20);
    // TX error with clean set in the same sample.
    rand_frame(6, fd);        run_frame(fd, 0, 1, 8'hA0);
    // Completion never signalled.
    rand_frame(3, fd);        run_frame(fd, 0, 0, 8'h00);
    // Boundaries: single byte, exactly MAX_LEN, MAX_LEN+1.
    rand_frame(1, fd);        run_frame(fd, 1, 2, 8'h20);
    rand_frame(MAXL, fd);     run_frame(fd, 0, 0, 8'h20);
    rand_frame(MAXL + 1, fd); run_frame(fd, 0, 0, 8'h20);

    for (int k = 0; k < 12; k++) begin
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(MAXL + 1, MAXL + 14)
                                        : $urandom_range(1, 40);
      rand_frame(len, fd);
      run_frame(fd, $urandom_range(0, 3), $urandom_range(0, 10), tr_tab[$urandom_range(0, 3)]);
    end
    check_stats("stat");

    // Leave err_code non-zero, then reset in the middle of a frame.
    rand_frame(2, fd);        run_frame(fd, 0, 0, 8'h00);
    rand_frame(6, fd);
    model_start(0, 0, 8'h20);
    push_byte(fd[0], 1'b0, ok);
    check("rst_byte0", ok, 1);
    push_byte(fd[1], 1'b0, ok);
    check("rst_byte1", ok, 1);
    check("rst_in_load", s_ready, 1);
    #2;
    reset = 1'b1;
    #1;
    outs = {csr_address, csr_read, csr_write, csr_writedata, s_ready, busy,
            frame_done, frame_err, err_code};
    check("midrst_outs", outs, 21'd0);
    s_valid = 1'b0;
    first_op = 0;
    ok_cnt = 0; err_cnt = 0; last_err = 2'd0;
    repeat (3) @(negedge clk);
    check("midrst_tx", tx_q.size(), 2);
    check_stats("rst_stat");
    reset = 1'b0;
    @(negedge clk);
    fd = fd[2:5];
    run_frame(fd, 0, 0, 8'h20);
    check("post_rst_first", first_op, 1);
    check_stats("final_stat");

    check("rd_wr_excl", rw_both, 0);
    check("csr_addr", bad_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
